maxnet_engine: RTL and testbench

Parametrised, self-sequencing MAXNET winner-take-all engine. Accepts N unsigned activations over a valid/ready stream, then iterates lateral inhibition with ε = 2^-EPS_SHIFT until at most one channel is non-zero or an iteration limit is reached. Returns the winner index, the winner's original input value, the iteration count and status flags over a valid/ready result port. Successor to the fixed 4-neuron, 5-bit MAXNET datapath: generic channel count, width, ε and iteration cap, with an internal FSM, handshakes, tie timeout and collapse detection.

---
 rtl/maxnet_engine.sv | 200 ++++++++++++++++++++
 tb/tb_maxnet_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_engine.sv
`timescale 1ns/1ps
// maxnet_engine
// Self-sequencing MAXNET winner-take-all engine. N unsigned activations are
// streamed in (channel 0 first). The engine then applies lateral inhibition
// with eps = 2^-EPS_SHIFT, one iteration per cycle, until at most one channel
// is non-zero, the iteration cap is reached, or the next update would zero
// every channel. It then presents the winner on a valid/ready result port.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   engine accepts input beats (high only while loading)
//   in_data    activation for the next channel
//   out_valid  result valid, held until accepted
//   out_ready  consumer accepts result
//   win_idx    winning channel (lowest-index non-zero channel)
//   win_value  original input value of the winner
//   iter_count committed inhibition iterations
//   timeout    stopped at MAX_ITER with two or more non-zero channels
//   collapse   next update would have zeroed every channel
//   no_winner  all channels were zero at check time
//
// state | meaning
// ------+----------------------------------------------------------
// LOAD  | accept N input beats into a[] and x[]
// ITER  | check for a result, else commit one inhibition iteration
// DONE  | hold registered result until out_ready

module maxnet_engine #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int EPS_SHIFT = 2,
  parameter int MAX_ITER  = 16,
  localparam int LW = $clog2(N),
  localparam int IW = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] win_idx,
  output logic [W-1:0]  win_value,
  output logic [IW-1:0] iter_count,
  output logic          timeout,
  output logic          collapse,
  output logic          no_winner
);

  // sum width is wide enough that the total of N full-scale values never wraps
  localparam int SW = W + $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  a [N];
  logic [W-1:0]  x [N];
  logic [LW-1:0] ld_idx;
  logic [IW-1:0] iter_cnt;

  logic [SW-1:0] total;
  logic [SW-1:0] inh [N];
  logic [W-1:0]  nxt [N];
  logic [CW-1:0] nz;
  logic [LW-1:0] first_idx;
  logic          next_all_zero;

  logic do_load, do_commit, do_finish, do_release;
  logic fin_to, fin_co, fin_nw;

  // inhibition datapath
  always_comb begin
    total         = '0;
    nz            = '0;
    first_idx     = '0;
    next_all_zero = 1'b1;
    for (int i = 0; i < N; i++) begin
      total = total + SW'(a[i]);
      if (a[i] != '0) nz = nz + CW'(1);
    end
    // descending scan so the lowest non-zero index wins
    for (int i = N - 1; i >= 0; i--) begin
      if (a[i] != '0) first_idx = LW'(i);
    end
    for (int i = 0; i < N; i++) begin
      inh[i] = (total - SW'(a[i])) >> EPS_SHIFT;
      nxt[i] = (SW'(a[i]) > inh[i]) ? W'(SW'(a[i]) - inh[i]) : '0;
      if (nxt[i] != '0) next_all_zero = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_LOAD;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    do_load    = 1'b0;
    do_commit  = 1'b0;
    do_finish  = 1'b0;
    do_release = 1'b0;
    fin_to     = 1'b0;
    fin_co     = 1'b0;
    fin_nw     = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          do_load = 1'b1;
          if (ld_idx == LW'(N - 1)) state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (nz == CW'(0)) begin
          do_finish = 1'b1;
          fin_nw    = 1'b1;
        end else if (nz == CW'(1)) begin
          do_finish = 1'b1;
        end else if (iter_cnt == IW'(MAX_ITER)) begin
          do_finish = 1'b1;
          fin_to    = 1'b1;
        end else if (next_all_zero) begin
          do_finish = 1'b1;
          fin_co    = 1'b1;
        end else begin
          do_commit = 1'b1;
        end
        if (do_finish) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          do_release = 1'b1;
          state_d    = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        a[i] <= '0;
        x[i] <= '0;
      end
      ld_idx     <= '0;
      iter_cnt   <= '0;
      win_idx    <= '0;
      win_value  <= '0;
      iter_count <= '0;
      timeout    <= 1'b0;
      collapse   <= 1'b0;
      no_winner  <= 1'b0;
    end else begin
      if (do_load) begin
        a[ld_idx] <= in_data;
        x[ld_idx] <= in_data;
        if (ld_idx == LW'(N - 1)) begin
          ld_idx   <= '0;
          iter_cnt <= '0;
        end else begin
          ld_idx <= ld_idx + LW'(1);
        end
      end
      if (do_commit) begin
        for (int i = 0; i < N; i++) a[i] <= nxt[i];
        iter_cnt <= iter_cnt + IW'(1);
      end
      if (do_finish) begin
        win_idx    <= fin_nw ? '0 : first_idx;
        win_value  <= fin_nw ? '0 : x[first_idx];
        iter_count <= iter_cnt;
        timeout    <= fin_to;
        collapse   <= fin_co;
        no_winner  <= fin_nw;
      end
      if (do_release) begin
        win_idx    <= '0;
        win_value  <= '0;
        iter_count <= '0;
        timeout    <= 1'b0;
        collapse   <= 1'b0;
        no_winner  <= 1'b0;
      end
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_maxnet_engine.sv
`timescale 1ns/1ps
// Testbench for maxnet_engine: one instance with default parameters and one
// with EPS_SHIFT=0, checked against a plain-arithmetic MAXNET reference.
module tb_maxnet_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv   [2];
  logic [7:0] id   [2];
  logic       ordy [2];
  logic       ir   [2];
  logic       ov   [2];
  logic [1:0] wi   [2];
  logic [7:0] wv   [2];
  logic [4:0] ic   [2];
  logic       to   [2];
  logic       co   [2];
  logic       nw   [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  maxnet_engine u_dut (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .win_idx(wi[0]), .win_value(wv[0]), .iter_count(ic[0]),
    .timeout(to[0]), .collapse(co[0]), .no_winner(nw[0])
  );

  maxnet_engine #(.EPS_SHIFT(0)) u_dut_e0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .win_idx(wi[1]), .win_value(wv[1]), .iter_count(ic[1]),
    .timeout(to[1]), .collapse(co[1]), .no_winner(nw[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: iterate the MAXNET rules on whole vectors with integer math.
  task automatic model(input int v[4], input int sh,
                       output int idx, output int val, output int it,
                       output int fto, output int fco, output int fnw);
    int a[4];
    int nx[4];
    int tot, nzc, allz;
    a = v; it = 0; idx = 0; val = 0; fto = 0; fco = 0; fnw = 0;
    for (int guard = 0; guard < 100; guard++) begin
      tot = 0; nzc = 0; idx = -1;
      for (int i = 0; i < 4; i++) begin
        tot += a[i];
        if (a[i] != 0) begin
          nzc++;
          if (idx < 0) idx = i;
        end
      end
      if (nzc == 0) begin idx = 0; val = 0; fnw = 1; return; end
      val = v[idx];
      if (nzc == 1) return;
      if (it == 16) begin fto = 1; return; end
      allz = 1;
      for (int i = 0; i < 4; i++) begin
        nx[i] = (a[i] > ((tot - a[i]) >> sh)) ? a[i] - ((tot - a[i]) >> sh) : 0;
        if (nx[i] != 0) allz = 0;
      end
      if (allz != 0) begin fco = 1; return; end
      a = nx;
      it++;
    end
  endtask

  task automatic chk_reset(input int s);
    chk("rst_in_ready", ir[s], 1);
    chk("rst_out_valid", ov[s], 0);
    chk("rst_win_idx", wi[s], 0);
    chk("rst_win_value", wv[s], 0);
    chk("rst_iter_count", ic[s], 0);
    chk("rst_flags", {to[s], co[s], nw[s]}, 0);
  endtask

  task automatic load_vec(input int s, input int v[4], input int bubbles);
    for (int c = 0; c < 4; c++) begin
      if (bubbles != 0) begin
        int gap = $urandom_range(0, 2);
        iv[s] = 1'b0;
        for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      end
      iv[s] = 1'b1;
      id[s] = v[c][7:0];
      chk("load_in_ready", ir[s], 1);
      @(posedge clk); #1;
    end
    iv[s] = 1'b0;
  endtask

  // Called right after the edge that took the last beat.
  task automatic finish_vec(input int s, input int v[4], input int stall);
    int e_idx, e_val, e_it, e_to, e_co, e_nw, n;
    model(v, (s == 0) ? 2 : 0, e_idx, e_val, e_it, e_to, e_co, e_nw);
    n = 0;
    while (!ov[s] && n < 60) begin @(posedge clk); #1; n++; end
    chk("latency", n + 1, e_it + 2);
    chk("win_idx", wi[s], e_idx);
    chk("win_value", wv[s], e_val);
    chk("iter_count", ic[s], e_it);
    chk("timeout", to[s], e_to);
    chk("collapse", co[s], e_co);
    chk("no_winner", nw[s], e_nw);
    chk("done_in_ready", ir[s], 0);
    for (int k = 0; k < stall; k++) begin
      iv[s] = 1'b1;
      id[s] = 8'($urandom);
      @(posedge clk); #1;
      chk("stall_out_valid", ov[s], 1);
      chk("stall_in_ready", ir[s], 0);
      chk("stall_result", {wi[s], wv[s], ic[s], to[s], co[s], nw[s]},
          {2'(e_idx), 8'(e_val), 5'(e_it), 1'(e_to), 1'(e_co), 1'(e_nw)});
    end
    iv[s] = 1'b0;
    ordy[s] = 1'b1;
    @(posedge clk); #1;
    ordy[s] = 1'b0;
    chk("release_in_ready", ir[s], 1);
    chk("release_out_valid", ov[s], 0);
    chk("release_flags", {to[s], co[s], nw[s]}, 0);
  endtask

  task automatic run_vec(input int s, input int v[4], input int bubbles, input int stall);
    load_vec(s, v, bubbles);
    finish_vec(s, v, stall);
  endtask

  initial begin
    int v[4];
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin iv[s] = 1'b0; id[s] = '0; ordy[s] = 1'b0; end
    #12;
    chk_reset(0);
    chk_reset(1);
    rst = 1'b1;
    @(posedge clk); #1;

    v = '{10, 20, 30, 40}; run_vec(0, v, 0, 0);
    v = '{0, 0, 7, 0};     run_vec(0, v, 0, 0);
    v = '{0, 0, 0, 0};     run_vec(0, v, 1, 0);
    v = '{50, 50, 0, 0};   run_vec(0, v, 0, 0);
    v = '{10, 10, 10, 10}; run_vec(1, v, 0, 0);
    v = '{200, 3, 90, 90}; run_vec(0, v, 1, 5);
    v = '{255, 255, 255, 255}; run_vec(0, v, 0, 0);

    // reset during the second load beat
    iv[0] = 1'b1; id[0] = 8'd5;
    @(posedge clk); #1;
    id[0] = 8'd6;
    #2 rst = 1'b0;
    #1 chk_reset(0);
    iv[0] = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // reset mid-iteration
    v = '{50, 50, 0, 0};
    load_vec(0, v, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_iter_busy", ov[0], 0);
    #2 rst = 1'b0;
    #1 chk_reset(0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    v = '{1, 9, 3, 2}; run_vec(0, v, 0, 0);

    for (int r = 0; r < 24; r++) begin
      int mode = $urandom_range(0, 3);
      for (int c = 0; c < 4; c++) begin
        case (mode)
          0: v[c] = $urandom_range(0, 255);
          1: v[c] = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 255) : 0;
          2: v[c] = $urandom_range(0, 15);
          default: v[c] = 0;
        endcase
      end
      if (mode == 3) begin
        int t = $urandom_range(1, 255);
        v[$urandom_range(0, 1)] = t;
        v[$urandom_range(2, 3)] = t;
      end
      run_vec(0, v, $urandom_range(0, 1), $urandom_range(0, 2));
    end
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 4; c++) v[c] = $urandom_range(0, 255);
      run_vec(1, v, $urandom_range(0, 1), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
